// File: rtl/csa_pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csa_pipe_adder_pkg
// Purpose  : Shared sizing helpers for the pipelined carry-save adder.
//            out_width() gives the output width that can hold the sum of N
//            full-scale operands, seg_width() the per-stage CPA slice width,
//            latency() the accept-to-valid_o distance in clock edges.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package csa_pipe_adder_pkg;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(4) = 2.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // N operands of W bits sum to at most N*(2^W-1) < 2^(W+clog2(N)).
    function automatic int out_width(input int width, input int operands);
        return width + clog2(operands);
    endfunction

    function automatic int seg_width(input int ow, input int segments);
        return (ow + segments - 1) / segments;
    endfunction

    // One CSA stage plus one register per CPA segment.
    function automatic int latency(input int segments);
        return segments + 1;
    endfunction

endpackage : csa_pipe_adder_pkg
`default_nettype wire

// File: rtl/csa_pipe_adder_csa_row.sv
`default_nettype none
// ============================================================================
// Module   : csa_row
// Purpose  : One combinational 3:2 compressor row. Reduces three vectors to
//            a sum vector and a carry vector already shifted into position,
//            so a + b + c == s_o + c_o (modulo 2^WIDTH).
// Ports    : a_i, b_i, c_i  - addends
//            s_o            - bitwise sum
//            c_o            - majority carries, shifted left by one
// Revision : 1.0 - initial release
// ============================================================================
module csa_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] c_o
);

    logic [WIDTH-1:0] w_maj;

    assign s_o   = a_i ^ b_i ^ c_i;
    assign w_maj = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    // The dropped top carry bit is always zero: callers size WIDTH so the
    // true total never reaches 2^WIDTH.
    assign c_o   = w_maj << 1;

endmodule : csa_row
`default_nettype wire

// File: rtl/csa_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : csa_pipe_adder
// Purpose  : Streaming multi-operand unsigned adder. Stage 0 reduces the
//            OPERANDS inputs to a sum/carry pair with a chain of 3:2 rows;
//            stages 1..SEGMENTS resolve that pair with a segmented
//            carry-propagate adder, one SEG_W slice per stage. The whole
//            pipe advances together under valid/ready flow control.
// Ports    : clk_i    - clock, rising edge
//            rst_ni   - asynchronous active-low reset
//            valid_i  - operand set present on ops_i
//            ready_o  - block accepts ops_i this cycle
//            ops_i    - operand k at [k*WIDTH +: WIDTH], unsigned
//            valid_o  - sum_o holds a result
//            ready_i  - consumer takes sum_o this cycle
//            sum_o    - exact sum, OW = WIDTH + clog2(OPERANDS) bits
// Revision : 1.0 - initial release
// ============================================================================
module csa_pipe_adder
    import csa_pipe_adder_pkg::*;
#(
    parameter  int WIDTH    = 64,
    parameter  int OPERANDS = 4,
    parameter  int SEGMENTS = 4,
    localparam int OW       = out_width(WIDTH, OPERANDS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [OPERANDS*WIDTH-1:0] ops_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [OW-1:0]             sum_o
);

    localparam int SEG_W = seg_width(OW, SEGMENTS);
    // Internal datapath is padded to a whole number of segments; the pad
    // bits are zero throughout, so the last segment behaves as a narrower one.
    localparam int PW    = SEG_W * SEGMENTS;

    // ------------------------------------------------------------------
    // Flow control: the pipe only holds when a result is waiting and the
    // consumer refuses it.
    // ------------------------------------------------------------------
    logic w_adv;
    assign w_adv   = ready_i | ~valid_o;
    assign ready_o = w_adv;

    // ------------------------------------------------------------------
    // Stage 0 combinational: zero-extend operands, 3:2 reduction chain.
    // Each row folds one more operand into the running (sum, carry) pair.
    // ------------------------------------------------------------------
    logic [PW-1:0] w_op    [OPERANDS];
    logic [PW-1:0] w_row_s [OPERANDS-1];
    logic [PW-1:0] w_row_c [OPERANDS-1];

    generate
        for (genvar k = 0; k < OPERANDS; k++) begin : g_op
            assign w_op[k] = PW'(ops_i[k*WIDTH +: WIDTH]);
        end
    endgenerate

    assign w_row_s[0] = w_op[0];
    assign w_row_c[0] = w_op[1];

    generate
        for (genvar r = 0; r < OPERANDS - 2; r++) begin : g_row
            csa_row #(
                .WIDTH (PW)
            ) u_row (
                .a_i (w_row_s[r]),
                .b_i (w_row_c[r]),
                .c_i (w_op[r+2]),
                .s_o (w_row_s[r+1]),
                .c_o (w_row_c[r+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage next-state values. Index k is what stage k would capture.
    // ------------------------------------------------------------------
    logic [PW-1:0] s_d  [SEGMENTS+1];
    logic [PW-1:0] c_d  [SEGMENTS+1];
    logic          cy_d [SEGMENTS+1];

    logic [PW-1:0]       s_q  [SEGMENTS];
    logic [PW-1:0]       c_q  [SEGMENTS];
    logic                cy_q [SEGMENTS];
    logic [SEGMENTS-1:0] v_q;
    logic [OW-1:0]       sum_q;
    logic                valid_q;

    assign s_d[0]  = w_row_s[OPERANDS-2];
    assign c_d[0]  = w_row_c[OPERANDS-2];
    assign cy_d[0] = 1'b0;

    // CPA segment k adds slice k-1 of the pair plus the carry left by the
    // previous segment. The finished slice overwrites the sum vector in
    // place, so s holds resolved low bits and still-pending high bits.
    generate
        for (genvar k = 1; k <= SEGMENTS; k++) begin : g_seg
            localparam int            LO       = (k - 1) * SEG_W;
            localparam logic [PW-1:0] SEG_MASK = PW'({SEG_W{1'b1}}) << LO;

            logic [SEG_W:0] w_add;

            assign w_add   = {1'b0, s_q[k-1][LO +: SEG_W]}
                           + {1'b0, c_q[k-1][LO +: SEG_W]}
                           + (SEG_W+1)'(cy_q[k-1]);
            assign s_d[k]  = (s_q[k-1] & ~SEG_MASK) | (PW'(w_add[SEG_W-1:0]) << LO);
            assign c_d[k]  = c_q[k-1] & ~SEG_MASK;
            assign cy_d[k] = w_add[SEG_W];
        end
    endgenerate

    // Carry out of the top segment and the leftover carry vector are zero
    // by construction; the upper pad bits of the final sum are also zero.
    logic w_unused;
    assign w_unused = ^{c_d[SEGMENTS], cy_d[SEGMENTS], s_d[SEGMENTS]};

    // ------------------------------------------------------------------
    // Datapath registers: no reset, loaded only when a valid set moves in,
    // so they never carry anything but real operand data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_adv && valid_i) begin
            s_q[0]  <= s_d[0];
            c_q[0]  <= c_d[0];
            cy_q[0] <= cy_d[0];
        end
        for (int k = 1; k < SEGMENTS; k++) begin
            if (w_adv && v_q[k-1]) begin
                s_q[k]  <= s_d[k];
                c_q[k]  <= c_d[k];
                cy_q[k] <= cy_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid chain and output register. sum_o only changes when a real
    // result arrives, so it stays bit-stable across bubbles and stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q     <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else if (w_adv) begin
            v_q[0] <= valid_i;
            for (int k = 1; k < SEGMENTS; k++) begin
                v_q[k] <= v_q[k-1];
            end
            valid_q <= v_q[SEGMENTS-1];
            if (v_q[SEGMENTS-1]) begin
                sum_q <= s_d[SEGMENTS][OW-1:0];
            end
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;

endmodule : csa_pipe_adder
`default_nettype wire

// File: tb/tb_csa_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_pipe_adder
// Purpose  : Directed self-checking bench. Instance A is the 64/4/4 default
//            configuration (OW 66, latency 5); instance B is 64/2/1
//            (OW 65, latency 2). Inputs change 1 time unit after a rising
//            edge; outputs are observed on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_pipe_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // Instance A: 64-bit, 4 operands, 4 segments
    logic         a_valid_i = 1'b0;
    logic         a_ready_i = 1'b1;
    logic [255:0] a_ops_i   = '0;
    logic         a_ready_o;
    logic         a_valid_o;
    logic [65:0]  a_sum_o;

    // Instance B: 64-bit, 2 operands, 1 segment
    logic         b_valid_i = 1'b0;
    logic         b_ready_i = 1'b1;
    logic [127:0] b_ops_i   = '0;
    logic         b_ready_o;
    logic         b_valid_o;
    logic [64:0]  b_sum_o;

    int n_tests = 0;
    int n_fail  = 0;

    csa_pipe_adder #(
        .WIDTH    (64),
        .OPERANDS (4),
        .SEGMENTS (4)
    ) dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (a_valid_i),
        .ready_o (a_ready_o),
        .ops_i   (a_ops_i),
        .valid_o (a_valid_o),
        .ready_i (a_ready_i),
        .sum_o   (a_sum_o)
    );

    csa_pipe_adder #(
        .WIDTH    (64),
        .OPERANDS (2),
        .SEGMENTS (1)
    ) dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (b_valid_i),
        .ready_o (b_ready_o),
        .ops_i   (b_ops_i),
        .valid_o (b_valid_o),
        .ready_i (b_ready_i),
        .sum_o   (b_sum_o)
    );

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: valid_o=%b expected 0", a_valid_o); end
        n_tests++;
        if (a_sum_o !== 66'd0) begin n_fail++; $display("FAIL reset_sum: sum_o=%h expected 0", a_sum_o); end
        n_tests++;
        if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: ready_o=%b expected 1", a_ready_o); end
        n_tests++;
        if (b_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: valid_o=%b expected 0", b_valid_o); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle: cycle %0d valid_o=%b expected 0", c, a_valid_o); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_max_operands;
        logic exp_v;
        @(posedge clk); #1;
        a_ready_i = 1'b1;
        a_valid_i = 1'b1;
        a_ops_i   = {4{64'hFFFF_FFFF_FFFF_FFFF}};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_v = (c == 5);
            n_tests++;
            if (a_valid_o !== exp_v) begin n_fail++; $display("FAIL max_valid: after %0d edges valid_o=%b expected %b", c, a_valid_o, exp_v); end
            if (c == 5) begin
                n_tests++;
                if (a_sum_o !== 66'h3_FFFF_FFFF_FFFF_FFFC) begin
                    n_fail++; $display("FAIL max_sum: sum_o=%h expected 3fffffffffffffffc", a_sum_o);
                end
            end
            @(posedge clk); #1;
            a_valid_i = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_ripple;
        int seen;
        seen = -1;
        @(posedge clk); #1;
        a_valid_i = 1'b1;
        a_ops_i   = {64'd0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int c = 0; c < 12 && seen < 0; c++) begin
            @(negedge clk);
            if (a_valid_o) begin
                seen = c;
                n_tests++;
                if (a_sum_o !== 66'h1_0000_0000_0000_0000) begin
                    n_fail++; $display("FAIL ripple_sum: sum_o=%h expected 10000000000000000", a_sum_o);
                end
            end
            @(posedge clk); #1;
            a_valid_i = 1'b0;
        end
        n_tests++;
        if (seen != 5) begin n_fail++; $display("FAIL ripple_latency: result at %0d edges expected 5", seen); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream_sweep;
        logic [63:0] vi [$];
        logic [63:0] vj [$];
        logic [65:0] exp_q [$];
        logic [65:0] e;
        int idx, got, first, last;
        idx = 0; got = 0; first = -1; last = -1;
        for (longint i = 1; i < 1000000; i *= 59)
            for (longint j = 1; j < 1000000; j *= 73) begin
                vi.push_back(64'(i));
                vj.push_back(64'(j));
            end
        @(posedge clk); #1;
        a_ready_i = 1'b1;
        a_valid_i = 1'b1;
        a_ops_i   = {64'd0, 64'd0, vj[0], vi[0]};
        for (int c = 0; c < 60 && got < vi.size(); c++) begin
            @(negedge clk);
            if (a_valid_o && a_ready_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL sweep_extra: cycle %0d sum_o=%h with no result outstanding", c, a_sum_o);
                end else begin
                    e = exp_q.pop_front();
                    if (a_sum_o !== e) begin n_fail++; $display("FAIL sweep_sum: result %0d sum_o=%h expected %h", got, a_sum_o, e); end
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (a_valid_i && a_ready_o) begin
                exp_q.push_back(66'(vi[idx]) + 66'(vj[idx]));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < vi.size()) begin
                a_valid_i = 1'b1;
                a_ops_i   = {64'd0, 64'd0, vj[idx], vi[idx]};
            end else begin
                a_valid_i = 1'b0;
            end
        end
        n_tests++;
        if (got != 16) begin n_fail++; $display("FAIL sweep_count: got %0d results expected 16", got); end
        n_tests++;
        if (first != 5) begin n_fail++; $display("FAIL sweep_latency: first result at %0d expected 5", first); end
        n_tests++;
        if (last - first != 15) begin n_fail++; $display("FAIL sweep_rate: span %0d cycles expected 15", last - first); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure;
        logic [255:0] ops [8];
        logic [65:0]  sums [8];
        logic [65:0]  exp_q [$];
        logic [65:0]  e;
        int idx, got;
        idx = 0; got = 0;
        for (int n = 0; n < 8; n++) begin
            ops[n]  = {64'h8000_0000_0000_0000, 64'(n) << 40,
                       64'hFFFF_FFFF_0000_0000, 64'hFEDC_BA98_7654_3210 + 64'(n)};
            sums[n] = 66'h8000_0000_0000_0000 + (66'(n) << 40)
                    + 66'hFFFF_FFFF_0000_0000 + 66'hFEDC_BA98_7654_3210 + 66'(n);
        end
        @(posedge clk); #1;
        a_ready_i = 1'b0;
        a_valid_i = 1'b1;
        a_ops_i   = ops[0];
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            if (c >= 5 && c <= 7) begin
                n_tests++;
                if (a_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: cycle %0d ready_o=%b expected 0", c, a_ready_o); end
                n_tests++;
                if (a_valid_o !== 1'b1 || a_sum_o !== sums[0]) begin
                    n_fail++; $display("FAIL bp_hold: cycle %0d valid_o=%b sum_o=%h expected 1 %h", c, a_valid_o, a_sum_o, sums[0]);
                end
            end
            if (a_valid_o && a_ready_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: cycle %0d sum_o=%h with no result outstanding", c, a_sum_o);
                end else begin
                    e = exp_q.pop_front();
                    if (a_sum_o !== e) begin n_fail++; $display("FAIL bp_sum: result %0d sum_o=%h expected %h", got, a_sum_o, e); end
                end
                got++;
            end
            if (a_valid_i && a_ready_o) begin
                exp_q.push_back(sums[idx]);
                idx++;
            end
            @(posedge clk); #1;
            a_ready_i = (c + 1 >= 8);
            if (idx < 8) begin
                a_valid_i = 1'b1;
                a_ops_i   = ops[idx];
            end else begin
                a_valid_i = 1'b0;
            end
        end
        a_ready_i = 1'b1;
        n_tests++;
        if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d results expected 8", got); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midstream;
        logic [65:0] exp_q [$];
        logic [65:0] e;
        int sent, got;
        sent = 0; got = 0;
        @(posedge clk); #1;
        a_ready_i = 1'b1;
        a_valid_i = 1'b1;
        a_ops_i   = {4{64'h1111_1111_1111_1111}};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            a_ops_i = {4{64'h1111_1111_1111_1111 * 64'(c + 2)}};
        end
        @(negedge clk);
        n_tests++;
        if (a_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_prefill: valid_o=%b expected 1", a_valid_o); end
        rst_n     = 1'b0;
        a_valid_i = 1'b0;
        #1;
        n_tests++;
        if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: valid_o=%b expected 0", a_valid_o); end
        n_tests++;
        if (a_sum_o !== 66'd0) begin n_fail++; $display("FAIL mid_async_sum: sum_o=%h expected 0", a_sum_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a_valid_i = 1'b1;
        a_ops_i   = {64'd0, 64'd0, 64'd100, 64'd7};
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (a_valid_o && a_ready_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL mid_stale: cycle %0d sum_o=%h with no result outstanding", c, a_sum_o);
                end else begin
                    e = exp_q.pop_front();
                    if (a_sum_o !== e) begin n_fail++; $display("FAIL mid_sum: sum_o=%h expected %h", a_sum_o, e); end
                end
                got++;
            end
            if (a_valid_i && a_ready_o) begin
                exp_q.push_back(66'd107 + 66'(sent));
                sent++;
            end
            @(posedge clk); #1;
            if (sent < 2) begin
                a_valid_i = 1'b1;
                a_ops_i   = {64'd0, 64'd0, 64'd101, 64'd7};
            end else begin
                a_valid_i = 1'b0;
            end
        end
        n_tests++;
        if (got != 2) begin n_fail++; $display("FAIL mid_count: got %0d results expected 2", got); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_two_operand_sweep;
        logic [63:0] vi [$];
        logic [63:0] vj [$];
        logic [64:0] exp_q [$];
        logic [64:0] e;
        int idx, got, first, last;
        idx = 0; got = 0; first = -1; last = -1;
        for (longint i = 1; i < 1000000; i *= 59)
            for (longint j = 1; j < 1000000; j *= 73) begin
                vi.push_back(64'(i));
                vj.push_back(64'(j));
            end
        // One full-scale pair to exercise the top carry of the 65-bit result.
        vi.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        vj.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        b_ready_i = 1'b1;
        b_valid_i = 1'b1;
        b_ops_i   = {vj[0], vi[0]};
        for (int c = 0; c < 60 && got < vi.size(); c++) begin
            @(negedge clk);
            if (b_valid_o && b_ready_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL two_extra: cycle %0d sum_o=%h with no result outstanding", c, b_sum_o);
                end else begin
                    e = exp_q.pop_front();
                    if (b_sum_o !== e) begin n_fail++; $display("FAIL two_sum: result %0d sum_o=%h expected %h", got, b_sum_o, e); end
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (b_valid_i && b_ready_o) begin
                exp_q.push_back(65'(vi[idx]) + 65'(vj[idx]));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < vi.size()) begin
                b_valid_i = 1'b1;
                b_ops_i   = {vj[idx], vi[idx]};
            end else begin
                b_valid_i = 1'b0;
            end
        end
        n_tests++;
        if (got != 17) begin n_fail++; $display("FAIL two_count: got %0d results expected 17", got); end
        n_tests++;
        if (first != 2) begin n_fail++; $display("FAIL two_latency: first result at %0d expected 2", first); end
        n_tests++;
        if (last - first != 16) begin n_fail++; $display("FAIL two_rate: span %0d cycles expected 16", last - first); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_max_operands();
        test_full_ripple();
        test_stream_sweep();
        test_backpressure();
        test_reset_midstream();
        test_two_operand_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule : tb_csa_pipe_adder
`default_nettype wire
